// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd engine and its dispatch front-end.
// Holds the dispatch FSM encoding and the common operand width.
package gcd_pkg;

  localparam int GCD_NBITS = 32;

  typedef enum logic [1:0] {
    GD_IDLE,
    GD_ISSUE,
    GD_WAIT
  } gd_state_e;

endpackage

// File: rtl/gcd_fifo.sv
// Synchronous FIFO buffering operand pairs ahead of the gcd engine.
// Push is refused when full and pop when empty; pointers wrap naturally.
module gcd_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/gcd_dispatch.sv
// Issues buffered operand pairs to the gcd engine one job at a time,
// registers the result for downstream and times out hung jobs.
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter  int NBITS   = GCD_NBITS,
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 1024,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int WW      = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_result,
  output logic             out_err,
  output logic [NBITS-1:0] gcd_a,
  output logic [NBITS-1:0] gcd_b,
  output logic             gcd_start,
  input  logic [NBITS-1:0] gcd_result,
  input  logic             gcd_done,
  output logic [CW-1:0]    fifo_count
);

  gd_state_e        state_q, state_d;
  logic [NBITS-1:0] op_a_q, op_a_d;
  logic [NBITS-1:0] op_b_q, op_b_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             ov_q, ov_d;
  logic [NBITS-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             start_q, start_d;

  logic [2*NBITS-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  gcd_fifo #(
    .W     (2*NBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wd_d    = wd_q;
    ov_d    = ov_q;
    res_d   = res_q;
    err_d   = err_q;
    pop     = 1'b0;
    if (ov_q && out_ready) ov_d = 1'b0;
    unique case (state_q)
      GD_IDLE: begin
        if (!empty && !ov_q) begin
          pop     = 1'b1;
          state_d = GD_ISSUE;
          op_a_d  = head[2*NBITS-1:NBITS];
          op_b_d  = head[NBITS-1:0];
        end
      end
      GD_ISSUE: begin
        state_d = GD_WAIT;
        wd_d    = '0;
      end
      GD_WAIT: begin
        wd_d = wd_q + 1'b1;
        // A done landing on the timeout cycle still wins.
        if (gcd_done) begin
          state_d = GD_IDLE;
          res_d   = gcd_result;
          err_d   = 1'b0;
          ov_d    = 1'b1;
        end else if (wd_q == WW'(TIMEOUT-1)) begin
          state_d = GD_IDLE;
          res_d   = '0;
          err_d   = 1'b1;
          ov_d    = 1'b1;
        end
      end
      default: state_d = GD_IDLE;
    endcase
    start_d = (state_d == GD_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GD_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wd_q    <= '0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      wd_q    <= wd_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign gcd_a      = op_a_q;
  assign gcd_b      = op_b_q;
  assign gcd_start  = start_q;
  assign out_valid  = ov_q;
  assign out_result = res_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with an engine model, a job-level
// reference model compared every cycle, and literal expectations.
module tb_gcd_dispatch;
  import gcd_pkg::*;

  localparam int NB      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NB-1:0] in_a = '0;
  logic [NB-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NB-1:0] out_result;
  logic          out_err;
  logic [NB-1:0] gcd_a;
  logic [NB-1:0] gcd_b;
  logic          gcd_start;
  logic [NB-1:0] gcd_result = '0;
  logic          gcd_done = 1'b0;
  logic [CW-1:0] fifo_count;

  gcd_dispatch #(
    .NBITS   (NB),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_start  (gcd_start),
    .gcd_result (gcd_result),
    .gcd_done   (gcd_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] ref_gcd(input logic [NB-1:0] a,
                                            input logic [NB-1:0] b);
    logic [NB-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Job-level reference model, updated on each rising edge.
  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
  } pair_t;

  pair_t         m_q[$];
  bit            m_on = 0;
  bit            m_busy = 0;
  bit            m_outv = 0;
  bit            m_err = 0;
  bit            m_start = 0;
  logic [NB-1:0] m_res = '0;
  logic [NB-1:0] m_a = '0;
  logic [NB-1:0] m_b = '0;
  longint        e = 0;
  longint        m_pop_e = 0;

  always @(posedge clk) begin
    int  pre_cnt;
    bit  pre_busy;
    bit  pre_outv;
    pair_t p;
    e++;
    if (reset) begin
      m_q.delete();
      m_on    = 1;
      m_busy  = 0;
      m_outv  = 0;
      m_err   = 0;
      m_res   = '0;
      m_a     = '0;
      m_b     = '0;
      m_start = 0;
    end else begin
      pre_cnt  = m_q.size();
      pre_busy = m_busy;
      pre_outv = m_outv;
      m_start  = 0;
      if (m_outv && out_ready) m_outv = 0;
      if (pre_busy) begin
        if (gcd_done && e >= m_pop_e + 2) begin
          m_busy = 0; m_outv = 1; m_err = 0; m_res = ref_gcd(m_a, m_b);
        end else if (e == m_pop_e + 1 + TIMEOUT) begin
          m_busy = 0; m_outv = 1; m_err = 1; m_res = '0;
        end
      end
      if (!pre_busy && !pre_outv && pre_cnt > 0) begin
        p = m_q.pop_front();
        m_a = p.a; m_b = p.b;
        m_busy = 1; m_pop_e = e; m_start = 1;
      end
      if (in_valid && pre_cnt < DEPTH) begin
        p.a = in_a; p.b = in_b;
        m_q.push_back(p);
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready", in_ready, m_q.size() < DEPTH);
      chk("fifo_count", fifo_count, m_q.size());
      chk("out_valid", out_valid, m_outv);
      chk("out_result", out_result, m_res);
      chk("out_err", out_err, m_err);
      chk("gcd_start", gcd_start, m_start);
      chk("gcd_a", gcd_a, m_a);
      chk("gcd_b", gcd_b, m_b);
    end
  end

  // Engine model: done after eng_lat WAIT cycles, never if negative.
  int            eng_lat = 5;
  bit            eng_busy = 0;
  int            eng_cnt = 0;
  logic [NB-1:0] eng_a, eng_b;
  bit            inj_done = 0;

  always @(posedge clk) begin
    #1;
    if (reset) eng_busy = 0;
    gcd_done = inj_done;
    if (eng_busy) begin
      chk("op_a_stable", gcd_a, eng_a);
      chk("op_b_stable", gcd_b, eng_b);
      if (eng_cnt == 0) begin
        gcd_done   = 1'b1;
        gcd_result = ref_gcd(eng_a, eng_b);
        eng_busy   = 0;
      end else begin
        eng_cnt--;
      end
    end else if (gcd_start === 1'b1 && eng_lat >= 0) begin
      eng_busy = 1;
      eng_cnt  = eng_lat - 1;
      eng_a    = gcd_a;
      eng_b    = gcd_b;
    end
  end

  int            ncyc = 0;
  int            n_start = 0;
  int            last_start_n = 0;
  int            last_rise_n = 0;
  logic          prev_ov = 1'b0;
  logic [NB-1:0] st_a, st_b;
  logic [NB-1:0] rx_res[$];
  logic          rx_err[$];

  always @(negedge clk) begin
    ncyc++;
    if (gcd_start === 1'b1) begin
      n_start++;
      last_start_n = ncyc;
      st_a = gcd_a;
      st_b = gcd_b;
    end
    if (out_valid === 1'b1 && prev_ov !== 1'b1) last_rise_n = ncyc;
    prev_ov = out_valid;
    #2;
    if (out_valid === 1'b1 && out_ready) begin
      rx_res.push_back(out_result);
      rx_err.push_back(out_err);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (in_ready !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("push_accepted", n < 200, 1'b1);
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int lim);
    int k;
    k = 0;
    while (rx_res.size() < n && k < lim) begin
      cyc(1);
      k++;
    end
    chk("rx_count", rx_res.size(), n);
  endtask

  initial begin
    int base;
    cyc(3);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_gcd_start", gcd_start, 1'b0);
    chk("rst_gcd_a", gcd_a, 0);
    reset = 1'b0;
    cyc(2);

    // Single job.
    eng_lat = 5;
    out_ready = 1'b1;
    push(48, 18);
    wait_rx(1, 100);
    chk("single_result", rx_res[0], 6);
    chk("single_err", rx_err[0], 1'b0);
    chk("single_starts", n_start, 1);
    chk("single_op_a", st_a, 48);
    chk("single_op_b", st_b, 18);
    cyc(3);

    // Back-pressure with pushes landing during WAIT.
    out_ready = 1'b0;
    base = n_start;
    push(21, 14);
    push(12, 8);
    push(7, 13);
    push(0, 9);
    push(100, 75);
    in_valid = 1'b1; in_a = 99; in_b = 33;
    cyc(3);
    in_valid = 1'b0;
    chk("bp_count_full", fifo_count, DEPTH);
    chk("bp_in_ready_low", in_ready, 1'b0);
    cyc(30);
    chk("bp_one_issue", n_start - base, 1);
    chk("bp_out_held", out_valid, 1'b1);
    out_ready = 1'b1;
    wait_rx(6, 300);
    chk("bp_r0", rx_res[1], 7);
    chk("bp_r1", rx_res[2], 4);
    chk("bp_r2", rx_res[3], 1);
    chk("bp_r3", rx_res[4], 9);
    chk("bp_r4", rx_res[5], 25);
    chk("bp_err", rx_err[5], 1'b0);
    chk("bp_issues", n_start - base, 5);
    cyc(3);

    // Watchdog timeout, then a late done.
    eng_lat = -1;
    push(9, 6);
    wait_rx(7, 100);
    chk("to_result", rx_res[6], 0);
    chk("to_err", rx_err[6], 1'b1);
    chk("to_latency", last_rise_n - last_start_n, TIMEOUT + 1);
    inj_done = 1'b1; gcd_result = 32'hdead;
    cyc(1);
    inj_done = 1'b0;
    cyc(5);
    chk("to_late_done", rx_res.size(), 7);

    // Done on the timeout cycle.
    eng_lat = TIMEOUT;
    push(35, 21);
    wait_rx(8, 100);
    chk("edge_result", rx_res[7], 7);
    chk("edge_err", rx_err[7], 1'b0);
    chk("edge_latency", last_rise_n - last_start_n, TIMEOUT + 1);
    cyc(3);

    // Reset mid-WAIT with two entries buffered.
    eng_lat = 10;
    push(8, 4);
    push(6, 4);
    push(10, 4);
    cyc(3);
    chk("mid_count", fifo_count, 2);
    base = n_start;
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_start", gcd_start, 1'b0);
    chk("mid_rst_gcd_a", gcd_a, 0);
    reset = 1'b0;
    inj_done = 1'b1; gcd_result = 32'hbeef;
    cyc(1);
    inj_done = 1'b0;
    cyc(20);
    chk("mid_stale_out", rx_res.size(), 8);
    chk("mid_no_issue", n_start, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/gcd_dispatch.md
# gcd_dispatch

Front-end stage for the `gcd` engine. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It issues one job at a time to the engine (`start` pulse, operands held stable), then captures `result` on `done` and presents it downstream with a valid/ready handshake. A watchdog converts a hung job into an error response.

## Interface
- `NBITS`, 32: operand and result width.
- `DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `TIMEOUT`, 1024: maximum cycles in WAIT before an error result is produced; ≥2.

- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO can accept; equals `!full`.
- `in_a`, `in_b`  in  NBITS each  operands.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  NBITS  GCD, or 0 on error.
- `out_err`  out  1  result produced by watchdog timeout.
- `gcd_a`, `gcd_b`  out  NBITS each  to engine `a_in`/`b_in`.
- `gcd_start`  out  1  to engine `start`; one-cycle pulse.
- `gcd_result`  in  NBITS  from engine `result`.
- `gcd_done`  in  1  from engine `done`; one-cycle pulse.
- `fifo_count`  out  $clog2(DEPTH)+1  entries buffered.

## Operation
- FIFO
  - Push when `in_valid && in_ready`.
  - `in_ready` is low whenever the FIFO is full, even if a pop occurs in the same cycle. There is no push-through when full.
  - Push and pop in the same cycle are legal when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when FIFO is non-empty and `out_valid == 0`.
    - On that edge: pop the head and load it into operand registers `op_a`/`op_b`.
  - ISSUE → WAIT unconditionally, after one cycle.
    - `gcd_start = 1` only while in ISSUE.
    - Clear the watchdog counter on this transition.
  - WAIT → IDLE on `gcd_done`.
    - `out_result <= gcd_result`, `out_err <= 0`, `out_valid <= 1`.
  - WAIT → IDLE when the watchdog counter reaches TIMEOUT-1 with no `gcd_done`.
    - `out_result <= 0`, `out_err <= 1`, `out_valid <= 1`.
  - `gcd_done` in the same cycle as the timeout takes precedence: the normal result is captured.
- `gcd_a`/`gcd_b` are driven from `op_a`/`op_b` at all times and are stable from ISSUE through WAIT.
- `gcd_done` outside WAIT is ignored.
- Output register
  - Cleared (`out_valid <= 0`) when `out_valid && out_ready`.
  - `out_result`/`out_err` hold until then.
  - Only one job is in flight. A new issue requires `out_valid == 0`, so a `done` always has a free output slot.
- Watchdog counter
  - Width $clog2(TIMEOUT).
  - Increments only in WAIT.
  - Saturation is not needed, because the FSM exits at TIMEOUT-1.
- Reset
  - FSM → IDLE; FIFO emptied (`fifo_count = 0`, `in_ready = 1`).
  - `out_valid = 0`, `out_err = 0`, `out_result = 0`.
  - `gcd_start = 0`; `op_a = op_b = 0`, so `gcd_a = gcd_b = 0`.
  - Reset mid-job discards the in-flight job and all buffered entries.
  - A later `gcd_done` from the engine is ignored because the FSM is in IDLE.

## Timing
- A pair pushed at edge N into an empty FIFO with the output free:
  - IDLE→ISSUE at edge N+1.
  - `gcd_start` high in cycle N+1..N+2.
  - WAIT from edge N+2.
- `gcd_done` sampled high at edge M → `out_valid` high from edge M; the FSM is in IDLE from edge M.
- If the FIFO is non-empty, the next issue occurs at the first edge where `out_valid` is 0. With `out_ready` held high, the job-to-job gap is 2 cycles after `done`.
- Timeout: with no `gcd_done`, `out_valid` rises TIMEOUT cycles after entering WAIT.
- All outputs are registered except `in_ready`, which is decoded from the registered count.

## Structure
- Package `gcd_pkg`:
  - FSM state enum (`GD_IDLE`, `GD_ISSUE`, `GD_WAIT`).
  - Default NBITS constant, shared with `gcd`.
- Sub-module `gcd_fifo`: parameterised synchronous FIFO with `push`/`pop`/`full`/`empty`/`count`, width 2*NBITS. Instantiated once.
- Top: FSM, operand registers, watchdog, output register.

## Test plan
- Single job, engine model returns after 5 cycles: push (48,18), `out_ready=1`.
  - `gcd_start` pulses exactly once with `gcd_a=48`, `gcd_b=18`.
  - `out_result=6`, `out_err=0`.
- Back-pressure: fill with 5 pairs, DEPTH=4, `out_ready=0`.
  - `in_ready` drops after 4 accepted pairs.
  - Only 1 job issues until `out_ready` rises.
  - All 4 buffered results then arrive in order: (12,8)→4, (7,13)→1, (0,9)→9, (100,75)→25.
- Operands stable: the engine model checks `gcd_a`/`gcd_b` remain unchanged every WAIT cycle, with a simultaneous push during WAIT.
- Timeout: TIMEOUT=16, engine never asserts `done`.
  - `out_valid` rises 16 cycles after entering WAIT with `out_result=0`, `out_err=1`.
  - A late `gcd_done` is ignored.
- `done` coinciding with the timeout cycle → normal result, `out_err=0`.
- Reset asserted mid-WAIT with 2 entries buffered.
  - Next cycle: `fifo_count=0`, `out_valid=0`, `gcd_start=0`.
  - A stale `done` produces no output.
